dmem_line_bridge: RTL and testbench
===================================

# dmem_line_bridge

Responder side of the pipeline data-memory port. Accepts the word-granular request the memory stage presents (address, byte read/write masks, write data), returns the aligned 32-bit word and the one-cycle `dmem_resp` that writeback consumes, and drives the global `freeze_stall` while a request is outstanding. Toward the system it is the initiator of a 64-bit burst memory interface. It keeps a one-line read buffer so repeated loads to the same 32-byte line avoid a burst.

## Interface
- `BEATS`, 4: 64-bit beats per line; the line is 32 bytes. Only 4 is supported.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `dmem_addr` in 32: request byte address. Must be held stable until `dmem_resp`.
- `dmem_rmask` in 4: read byte mask. Nonzero means a read request.
- `dmem_wmask` in 4: write byte mask. Nonzero means a write request.
- `dmem_wdata` in 32: store data, already lane-aligned.
- `dmem_rdata` out 32: aligned word `line[addr[4:2]]`. Byte/half extraction is done downstream.
- `dmem_resp` out 1: one-cycle completion pulse.
- `freeze_stall` out 1: stall for the whole pipeline.
- `bmem_addr` out 32: burst address.
- `bmem_read` out 1: line read command.
- `bmem_write` out 1: single-beat write command.
- `bmem_wdata` out 64: write beat.
- `bmem_wmask` out 8: write beat byte mask.
- `bmem_ready` in 1: command accepted this cycle.
- `bmem_rdata` in 64: read beat.
- `bmem_rvalid` in 1: read beat valid. Beats arrive in ascending order, 0..3.

## Operation
- Request presence: `req = |dmem_rmask | |dmem_wmask`.
- If both masks are nonzero, the request is handled as a write and the read data is undefined.
- Line buffer: `lb_valid`, `lb_tag = addr[31:5]`, `lb_data` (256 bits).
- Hit: `lb_valid && lb_tag == dmem_addr[31:5]`.
- FSM states: IDLE, RD_CMD, RD_BEATS, WR_CMD, RESP.
- IDLE transitions:
  - read hit → RESP; `dmem_rdata` is loaded from the buffer.
  - read miss → RD_CMD.
  - write → WR_CMD.
  - no request → stay in IDLE.
- RD_CMD:
  - `bmem_read=1`, `bmem_addr = {addr[31:5],5'b0}`.
  - Held until `bmem_ready`, then → RD_BEATS with beat counter = 0.
- RD_BEATS:
  - Each `bmem_rvalid` stores the beat at `lb_data[64*cnt +: 64]` and increments the 2-bit counter.
  - On the 4th beat: set `lb_valid=1`, write `lb_tag`, load `dmem_rdata` from the assembled line (the 4th beat is bypassed in), → RESP.
- WR_CMD:
  - `bmem_write=1`, `bmem_addr = {addr[31:3],3'b0}`.
  - `bmem_wdata = {dmem_wdata, dmem_wdata}`.
  - `bmem_wmask = addr[2] ? {wmask,4'b0} : {4'b0,wmask}`.
  - Held until `bmem_ready`. On acceptance, if hit, merge the masked bytes into `lb_data` (write-through, no allocate on miss), then → RESP.
- RESP: `dmem_resp=1` for exactly one cycle, then → IDLE.
- `freeze_stall = req && !dmem_resp` (combinational).
- `dmem_rdata` is registered and holds its value until the next read completion.
- `bmem_rvalid` outside RD_BEATS is ignored.
- `bmem_*` command outputs are 0 outside their states; address and data are 0 when idle.

## Timing
- Reset values:
  - state IDLE, `lb_valid=0`, counter 0.
  - `dmem_resp=0`, `dmem_rdata=0`.
  - `bmem_read=0`, `bmem_write=0`, `bmem_addr=0`, `bmem_wdata=0`, `bmem_wmask=0`.
  - `freeze_stall` follows inputs (0 when there is no request).
- Read hit: request sampled in IDLE at cycle N; `dmem_resp` high at N+1.
- Read miss: command accepted at cycle A, last beat at cycle B; `dmem_resp` at B+1.
- Write: `bmem_ready` at cycle A; `dmem_resp` at A+1.
- Back-to-back requests: the next request is sampled in IDLE the cycle after RESP. Peak rate is one hit every 2 cycles.
- Reset mid-burst: return to IDLE, invalidate the buffer, and drop the remaining beats.
- Beats and ready may arrive with any number of idle cycles between them. There is no timeout.

## Configuration
- `DMEM_LINEBUF_EN` defined: line buffer is present as described above.
- Undefined:
  - `lb_valid` is tied 0, so every read takes the RD_CMD/RD_BEATS path.
  - The assembled line is used only to produce `dmem_rdata`.
  - Write merge is removed.
  - Interface and timing are otherwise identical.

## Test plan
- Reset, then read `rmask=F` at `0x100`; memory returns beats `0x11..11, 0x22..22, 0x33..33, 0x44..44` → one `bmem_read` with `bmem_addr=0x100`; `dmem_rdata=0x11111111`; `freeze_stall` high until `resp`.
- Next read at `0x11C` (same line) → no `bmem_read`; `dmem_resp` one cycle after the request; `dmem_rdata=0x44444444`. With the macro undefined, a burst is issued instead.
- Write `wmask=4'b0011`, `wdata=0xAAAABBBB` at `0x104` → `bmem_addr=0x100`, `bmem_wmask=8'h30`; a following read at `0x104` (hit) returns `0x1111BBBB`.
- `bmem_ready` withheld 5 cycles and beats spaced 2 cycles apart → command held stable; `dmem_resp` exactly one cycle after the 4th beat; stray `rvalid` in IDLE has no effect.
- Assert `rst` after the 2nd beat → IDLE, `resp=0`; a subsequent read of the same line issues a new burst.

Source files
------------

// File: rtl/dmem_line_bridge.sv
// dmem_line_bridge: responder for the pipeline data-memory port and initiator of a
// 64-bit burst memory interface. A one-line (32-byte) read buffer lets repeated loads
// to the same line complete without a burst. Writes are single-beat write-through.
// Optional feature macro: DMEM_LINEBUF_EN
//   defined   -> the line buffer can hit, and writes that hit merge into it
//   undefined -> every read bursts; the assembled line only feeds dmem_rdata
module dmem_line_bridge #(
  parameter int BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        freeze_stall,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [63:0] bmem_wdata,
  output logic [7:0]  bmem_wmask,
  input  logic        bmem_ready,
  input  logic [63:0] bmem_rdata,
  input  logic        bmem_rvalid
);

  localparam int LINE_BITS = 64 * BEATS;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_BEATS,
    WR_CMD,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 lb_valid_q, lb_valid_d;
  logic [26:0]          lb_tag_q, lb_tag_d;
  logic [LINE_BITS-1:0] lb_data_q, lb_data_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 resp_q, resp_d;
  logic                 bread_q, bread_d;
  logic                 bwrite_q, bwrite_d;
  logic [31:0]          baddr_q, baddr_d;
  logic [63:0]          bwdata_q, bwdata_d;
  logic [7:0]           bwmask_q, bwmask_d;

  logic                 rd_req;
  logic                 wr_req;
  logic                 req;
  logic                 hit;
  logic [2:0]           word_sel;
  logic [LINE_BITS-1:0] line_full;
  logic                 unused_addr_bits;

  assign rd_req   = |dmem_rmask;
  assign wr_req   = |dmem_wmask;
  assign req      = rd_req | wr_req;
  assign hit      = lb_valid_q && (lb_tag_q == dmem_addr[31:5]);
  assign word_sel = dmem_addr[4:2];
  // The final beat is bypassed in so the word is ready the same cycle the line completes.
  assign line_full = {bmem_rdata, lb_data_q[LINE_BITS-65:0]};
  // Byte offset within the word is resolved downstream.
  assign unused_addr_bits = ^dmem_addr[1:0];

`ifdef DMEM_LINEBUF_EN
  // Line image with the store's enabled bytes merged into the addressed word.
  logic [LINE_BITS-1:0] merged_line;
  for (genvar gi = 0; gi < LINE_BITS / 8; gi++) begin : g_merge
    localparam logic [2:0] WORD = 3'(gi / 4);
    localparam int         LANE = gi % 4;
    assign merged_line[8*gi +: 8] = (word_sel == WORD && dmem_wmask[LANE])
                                    ? dmem_wdata[8*LANE +: 8]
                                    : lb_data_q[8*gi +: 8];
  end
`endif

  // Next-state and next-output computation for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lb_valid_d = lb_valid_q;
    lb_tag_d   = lb_tag_q;
    lb_data_d  = lb_data_q;
    rdata_d    = rdata_q;
    resp_d     = 1'b0;
    bread_d    = 1'b0;
    bwrite_d   = 1'b0;
    baddr_d    = 32'd0;
    bwdata_d   = 64'd0;
    bwmask_d   = 8'd0;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          // A request with both masks set is treated as a write.
          state_d  = WR_CMD;
          bwrite_d = 1'b1;
          baddr_d  = {dmem_addr[31:3], 3'b000};
          bwdata_d = {dmem_wdata, dmem_wdata};
          bwmask_d = dmem_addr[2] ? {dmem_wmask, 4'b0000} : {4'b0000, dmem_wmask};
        end else if (rd_req) begin
          if (hit) begin
            state_d = RESP;
            resp_d  = 1'b1;
            rdata_d = lb_data_q[{word_sel, 5'b00000} +: 32];
          end else begin
            state_d = RD_CMD;
            bread_d = 1'b1;
            baddr_d = {dmem_addr[31:5], 5'b00000};
          end
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          state_d = RD_BEATS;
          cnt_d   = 2'd0;
        end else begin
          bread_d = 1'b1;
          baddr_d = baddr_q;
        end
      end
      RD_BEATS: begin
        if (bmem_rvalid) begin
          lb_data_d[{cnt_q, 6'b000000} +: 64] = bmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef DMEM_LINEBUF_EN
            lb_valid_d = 1'b1;
`endif
            lb_tag_d = dmem_addr[31:5];
            rdata_d  = line_full[{word_sel, 5'b00000} +: 32];
            state_d  = RESP;
            resp_d   = 1'b1;
          end
        end
      end
      WR_CMD: begin
        if (bmem_ready) begin
`ifdef DMEM_LINEBUF_EN
          // Write-through: keep the buffered line coherent, never allocate on a miss.
          if (hit) begin
            lb_data_d = merged_line;
          end
`endif
          state_d = RESP;
          resp_d  = 1'b1;
        end else begin
          bwrite_d = 1'b1;
          baddr_d  = baddr_q;
          bwdata_d = bwdata_q;
          bwmask_d = bwmask_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, line buffer and registered outputs; reset also invalidates the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      lb_valid_q <= 1'b0;
      lb_tag_q   <= 27'd0;
      lb_data_q  <= '0;
      rdata_q    <= 32'd0;
      resp_q     <= 1'b0;
      bread_q    <= 1'b0;
      bwrite_q   <= 1'b0;
      baddr_q    <= 32'd0;
      bwdata_q   <= 64'd0;
      bwmask_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lb_valid_q <= lb_valid_d;
      lb_tag_q   <= lb_tag_d;
      lb_data_q  <= lb_data_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      bread_q    <= bread_d;
      bwrite_q   <= bwrite_d;
      baddr_q    <= baddr_d;
      bwdata_q   <= bwdata_d;
      bwmask_q   <= bwmask_d;
    end
  end

  assign dmem_rdata   = rdata_q;
  assign dmem_resp    = resp_q;
  assign freeze_stall = req && !resp_q;
  assign bmem_read    = bread_q;
  assign bmem_write   = bwrite_q;
  assign bmem_addr    = baddr_q;
  assign bmem_wdata   = bwdata_q;
  assign bmem_wmask   = bwmask_q;

endmodule

// File: tb/tb_dmem_line_bridge.sv
// Testbench for dmem_line_bridge: directed test-plan steps followed by random
// requests, checked against a byte-level memory model and a line-buffer model.
module tb_dmem_line_bridge;

`ifdef DMEM_LINEBUF_EN
  localparam bit LB_EN = 1'b1;
`else
  localparam bit LB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        freeze_stall;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic [7:0]  bmem_wmask;
  logic        bmem_ready;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  dmem_line_bridge #(.BEATS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .dmem_addr    (dmem_addr),
    .dmem_rmask   (dmem_rmask),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .freeze_stall (freeze_stall),
    .bmem_addr    (bmem_addr),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_wmask   (bmem_wmask),
    .bmem_ready   (bmem_ready),
    .bmem_rdata   (bmem_rdata),
    .bmem_rvalid  (bmem_rvalid)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state
  logic [63:0] mem [bit [28:0]];
  bit          lb_v = 1'b0;
  logic [26:0] lb_line = '0;
  logic [31:0] last_rdata = '0;
  bit          rdata_known = 1'b1;

  // Current request, shared with the memory responder
  logic [31:0] cur_addr = '0;
  logic [3:0]  cur_wmask = '0;
  logic [31:0] cur_wdata = '0;

  // Responder knobs and observations
  int ready_delay = 0;
  int beat_gap = 0;
  bit stray_req = 1'b0;
  int burst_cnt = 0;
  int wr_cnt = 0;
  int beats_done = 0;
  int last_beat_cyc = 0;
  int ready_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_beat(input logic [28:0] idx);
    if (!mem.exists(idx)) mem[idx] = {$urandom, $urandom};
    return mem[idx];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [63:0] b;
    b = get_beat(a[31:3]);
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [3:0] wm,
                                      input logic [31:0] wd);
    logic [63:0] b;
    int base;
    b = get_beat(a[31:3]);
    base = a[2] ? 32 : 0;
    for (int i = 0; i < 4; i++) begin
      if (wm[i]) b[base + 8*i +: 8] = wd[8*i +: 8];
    end
    mem[a[31:3]] = b;
  endfunction

  // Burst memory responder: programmable ready delay and beat spacing.
  initial begin
    int wait_cnt;
    int gap_cnt;
    int beats_left;
    logic [28:0] base;
    logic [7:0]  exp_wm;
    wait_cnt = 0;
    gap_cnt = 0;
    beats_left = 0;
    base = '0;
    bmem_ready = 1'b0;
    bmem_rvalid = 1'b0;
    bmem_rdata = '0;
    forever begin
      @(negedge clk);
      bmem_ready = 1'b0;
      bmem_rvalid = 1'b0;
      bmem_rdata = '0;
      if (rst) begin
        beats_left = 0;
        wait_cnt = 0;
        gap_cnt = 0;
      end else if (beats_left > 0) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          bmem_rvalid = 1'b1;
          bmem_rdata = get_beat(base + 29'(4 - beats_left));
          beats_left--;
          beats_done++;
          gap_cnt = beat_gap;
          if (beats_left == 0) last_beat_cyc = cyc;
        end
      end else if (bmem_read || bmem_write) begin
        chk("cmd_is_write", bmem_write, |cur_wmask);
        chk("cmd_is_read", bmem_read, ~|cur_wmask);
        if (|cur_wmask) begin
          exp_wm = {4'b0000, cur_wmask} << (cur_addr[2] ? 4 : 0);
          chk("wr_addr", bmem_addr, {cur_addr[31:3], 3'b000});
          chk("wr_data", bmem_wdata, {cur_wdata, cur_wdata});
          chk("wr_mask", bmem_wmask, exp_wm);
        end else begin
          chk("rd_addr", bmem_addr, {cur_addr[31:5], 5'b00000});
        end
        if (wait_cnt < ready_delay) begin
          wait_cnt++;
        end else begin
          bmem_ready = 1'b1;
          wait_cnt = 0;
          ready_cyc = cyc;
          if (bmem_read) begin
            burst_cnt++;
            base = {cur_addr[31:5], 2'b00};
            beats_left = 4;
            gap_cnt = 0;
            beats_done = 0;
          end else begin
            wr_cnt++;
          end
        end
      end else if (stray_req) begin
        bmem_rvalid = 1'b1;
        bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        stray_req = 1'b0;
      end
    end
  end

  // One request from the memory stage, driven at a negedge and held until dmem_resp.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd);
    bit is_wr;
    bit exp_burst;
    int b0;
    int w0;
    int start;
    int n;
    logic [31:0] exp_word;
    is_wr = |wm;
    exp_burst = !is_wr && !(LB_EN && lb_v && lb_line == a[31:5]);
    b0 = burst_cnt;
    w0 = wr_cnt;
    cur_addr = a;
    cur_wmask = wm;
    cur_wdata = wd;
    dmem_addr = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    start = cyc;
    #1;
    chk("stall_on_request", freeze_stall, 1'b1);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (dmem_resp === 1'b1) break;
      chk("stall_while_waiting", freeze_stall, 1'b1);
    end
    chk("resp_seen", dmem_resp, 1'b1);
    chk("stall_released_at_resp", freeze_stall, 1'b0);
    if (!is_wr) begin
      exp_word = model_word(a);
      chk("read_data", dmem_rdata, exp_word);
      last_rdata = exp_word;
      rdata_known = 1'b1;
    end else begin
      if (rm == 4'd0 && rdata_known) chk("rdata_held_on_write", dmem_rdata, last_rdata);
      if (rm != 4'd0) rdata_known = 1'b0;
      model_write(a, wm, wd);
    end
    chk("burst_count", 64'(burst_cnt - b0), exp_burst ? 64'd1 : 64'd0);
    chk("write_count", 64'(wr_cnt - w0), is_wr ? 64'd1 : 64'd0);
    if (is_wr) chk("write_latency", 64'(cyc), 64'(ready_cyc + 1));
    else if (exp_burst) chk("miss_latency", 64'(cyc), 64'(last_beat_cyc + 1));
    else chk("hit_latency", 64'(cyc), 64'(start + 1));
    if (exp_burst && LB_EN) begin
      lb_v = 1'b1;
      lb_line = a[31:5];
    end
    dmem_rmask = 4'd0;
    dmem_wmask = 4'd0;
    @(negedge clk);
    chk("resp_one_cycle", dmem_resp, 1'b0);
    chk("stall_idle", freeze_stall, 1'b0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    logic [3:0]  rm;
    logic [3:0]  wm;
    int kind;
    rst = 1'b1;
    dmem_addr = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    mem[29'h20] = 64'h1111_1111_1111_1111;
    mem[29'h21] = 64'h2222_2222_2222_2222;
    mem[29'h22] = 64'h3333_3333_3333_3333;
    mem[29'h23] = 64'h4444_4444_4444_4444;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_resp", dmem_resp, 1'b0);
    chk("rst_rdata", dmem_rdata, 32'd0);
    chk("rst_stall", freeze_stall, 1'b0);
    chk("rst_bread", bmem_read, 1'b0);
    chk("rst_bwrite", bmem_write, 1'b0);
    chk("rst_baddr", bmem_addr, 32'd0);
    chk("rst_bwdata", bmem_wdata, 64'd0);
    chk("rst_bwmask", bmem_wmask, 8'd0);

    // Test-plan directed sequence
    ready_delay = 0;
    beat_gap = 0;
    do_req(32'h100, 4'hF, 4'h0, 32'h0);
    chk("tp_first_word", dmem_rdata, 32'h1111_1111);
    do_req(32'h11C, 4'hF, 4'h0, 32'h0);
    chk("tp_same_line_word", dmem_rdata, 32'h4444_4444);
    do_req(32'h104, 4'h0, 4'b0011, 32'hAAAA_BBBB);
    do_req(32'h104, 4'hF, 4'h0, 32'h0);
    chk("tp_merged_word", dmem_rdata, 32'h1111_BBBB);

    // Slow memory: ready withheld 5 cycles, beats two cycles apart
    ready_delay = 5;
    beat_gap = 1;
    do_req(32'h180, 4'hF, 4'h0, 32'h0);
    do_req(32'h188, 4'h0, 4'b1100, 32'h1234_5678);

    // Stray rvalid while idle, then a read of the buffered line
    ready_delay = 0;
    beat_gap = 0;
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    do_req(32'h184, 4'hF, 4'h0, 32'h0);
    do_req(32'h188, 4'h3, 4'h0, 32'h0);

    // Reset after the second beat of a burst
    beat_gap = 1;
    beats_done = 0;
    cur_addr = 32'h400;
    cur_wmask = 4'h0;
    dmem_addr = 32'h400;
    dmem_rmask = 4'hF;
    n = 0;
    while (beats_done < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midburst_two_beats", beats_done >= 2, 1'b1);
    rst = 1'b1;
    dmem_rmask = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midburst_resp", dmem_resp, 1'b0);
    chk("midburst_bread", bmem_read, 1'b0);
    chk("midburst_rdata", dmem_rdata, 32'd0);
    chk("midburst_stall", freeze_stall, 1'b0);
    lb_v = 1'b0;
    last_rdata = 32'd0;
    rdata_known = 1'b1;
    repeat (3) @(negedge clk);
    do_req(32'h408, 4'hF, 4'h0, 32'h0);

    // Random traffic over four lines
    for (int i = 0; i < 40; i++) begin
      ready_delay = $urandom_range(0, 3);
      beat_gap = $urandom_range(0, 2);
      a = 32'h200 + 32'($urandom_range(0, 3)) * 32 + 32'($urandom_range(0, 7)) * 4;
      kind = $urandom_range(0, 7);
      rm = 4'h0;
      wm = 4'h0;
      if (kind <= 4) rm = 4'($urandom_range(1, 15));
      else if (kind <= 6) wm = 4'($urandom_range(1, 15));
      else begin
        rm = 4'($urandom_range(1, 15));
        wm = 4'($urandom_range(1, 15));
      end
      do_req(a, rm, wm, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
